lcd_ctrl: RTL and testbench

Character-LCD controller for the HD44780-compatible 16x2 panel on the board. It sits on the other side of the LSU's LCD output port. It accepts one byte-write request at a time from the memory-mapped I/O side and runs the panel's power-on initialisation by itself. For each request it generates the RS/RW/EN/DATA pin sequencing with the panel's setup, pulse-width and execution-time waits. The panel is write-only (RW tied low); busy status is reported back through `req_ready` and `status`, never read from the panel.

---
 rtl/lcd_ctrl.sv | 170 +++++++++++++++++
 tb/tb_lcd_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_ctrl.sv
// HD44780-compatible character-LCD controller: runs the panel power-on init
// sequence, then writes one instruction/data byte per accepted request.
module lcd_ctrl #(
  parameter int T_PWRON = 750000,
  parameter int T_SETUP = 2,
  parameter int T_EN    = 12,
  parameter int T_CMD   = 2000,
  parameter int T_CLR   = 82000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_rs,
  input  logic [7:0]  req_data,
  output logic        req_ready,
  output logic        init_done,
  output logic [31:0] status,
  output logic        lcd_on,
  output logic        lcd_en,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic [7:0]  lcd_data
);

  localparam int T_MAX_A = (T_PWRON > T_CLR) ? T_PWRON : T_CLR;
  localparam int T_MAX_B = (T_CMD > T_EN) ? T_CMD : T_EN;
  localparam int T_MAX_C = (T_MAX_B > T_SETUP) ? T_MAX_B : T_SETUP;
  localparam int T_MAX   = (T_MAX_A > T_MAX_C) ? T_MAX_A : T_MAX_C;
  localparam int CNT_W   = $clog2(T_MAX + 1);

  localparam logic [2:0] S_PWR_WAIT = 3'd0;
  localparam logic [2:0] S_SETUP    = 3'd1;
  localparam logic [2:0] S_EN_HI    = 3'd2;
  localparam logic [2:0] S_EXEC     = 3'd3;
  localparam logic [2:0] S_IDLE     = 3'd4;

  localparam logic [2:0] INIT_LAST = 3'd5;

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_init_idx;
  logic             r_lcd_en;
  logic             r_lcd_rs;
  logic [7:0]       r_lcd_data;
  logic             r_lcd_on;
  logic             r_req_ready;
  logic             r_init_done;

  logic [CNT_W-1:0] w_last;
  logic             w_cnt_hit;
  logic             w_long_exec;
  logic [2:0]       w_next_idx;

  function automatic logic [7:0] init_byte(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: init_byte = 8'h38;
      3'd3:             init_byte = 8'h0C;
      3'd4:             init_byte = 8'h01;
      3'd5:             init_byte = 8'h06;
      default:          init_byte = 8'h00;
    endcase
  endfunction

  // Clear-display and return-home need the long execution wait.
  assign w_long_exec = !r_lcd_rs && (r_lcd_data == 8'h01 || r_lcd_data == 8'h02 ||
                                     r_lcd_data == 8'h03);
  assign w_next_idx  = r_init_idx + 3'd1;

  always_comb begin
    // NOTE: default first so every path assigns w_last and no latch is inferred.
    w_last = '0;
    case (r_state)
      S_PWR_WAIT: w_last = CNT_W'(T_PWRON - 1);
      S_SETUP:    w_last = CNT_W'(T_SETUP - 1);
      S_EN_HI:    w_last = CNT_W'(T_EN - 1);
      S_EXEC:     w_last = w_long_exec ? CNT_W'(T_CLR - 1) : CNT_W'(T_CMD - 1);
      default:    w_last = '0;
    endcase
  end

  assign w_cnt_hit = (r_cnt == w_last);

  // NOTE: state uses non-blocking assignments; reset is synchronous, so it
  // lives inside the clocked block rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_PWR_WAIT;
      r_cnt       <= '0;
      r_init_idx  <= '0;
      r_lcd_en    <= 1'b0;
      r_lcd_rs    <= 1'b0;
      r_lcd_data  <= 8'h00;
      r_lcd_on    <= 1'b0;
      r_req_ready <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_lcd_on <= 1'b1;
      case (r_state)
        S_PWR_WAIT: begin
          if (w_cnt_hit) begin
            r_cnt      <= '0;
            r_init_idx <= '0;
            r_lcd_rs   <= 1'b0;
            r_lcd_data <= init_byte(3'd0);
            r_state    <= S_SETUP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_SETUP: begin
          if (w_cnt_hit) begin
            r_cnt    <= '0;
            r_lcd_en <= 1'b1;
            r_state  <= S_EN_HI;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_EN_HI: begin
          if (w_cnt_hit) begin
            r_cnt    <= '0;
            r_lcd_en <= 1'b0;
            r_state  <= S_EXEC;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_EXEC: begin
          if (w_cnt_hit) begin
            r_cnt <= '0;
            if (!r_init_done && r_init_idx != INIT_LAST) begin
              r_init_idx <= w_next_idx;
              r_lcd_data <= init_byte(w_next_idx);
              r_state    <= S_SETUP;
            end else begin
              r_init_done <= 1'b1;
              r_req_ready <= 1'b1;
              r_state     <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_IDLE: begin
          if (req_valid && r_req_ready) begin
            r_cnt       <= '0;
            r_lcd_rs    <= req_rs;
            r_lcd_data  <= req_data;
            r_req_ready <= 1'b0;
            r_state     <= S_SETUP;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= S_PWR_WAIT;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign init_done = r_init_done;
  assign status    = {30'b0, r_init_done, ~r_req_ready};
  assign lcd_on    = r_lcd_on;
  assign lcd_en    = r_lcd_en;
  assign lcd_rs    = r_lcd_rs;
  assign lcd_rw    = 1'b0;
  assign lcd_data  = r_lcd_data;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with short timing parameters; an EN-pulse
// monitor records every strobe so sequences can be compared afterwards.
module tb_lcd_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_rs;
  logic [7:0]  req_data;
  logic        req_ready;
  logic        init_done;
  logic [31:0] status;
  logic        lcd_on;
  logic        lcd_en;
  logic        lcd_rs;
  logic        lcd_rw;
  logic [7:0]  lcd_data;

  int n_checks = 0;
  int n_errors = 0;

  lcd_ctrl #(
    .T_PWRON(10), .T_SETUP(2), .T_EN(3), .T_CMD(5), .T_CLR(20)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_rs(req_rs), .req_data(req_data),
    .req_ready(req_ready), .init_done(init_done), .status(status),
    .lcd_on(lcd_on), .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_data(lcd_data)
  );

  always #5 clk = ~clk;

  // EN-pulse monitor, sampled on the falling edge.
  int         cyc = 0;
  int         width = 0;
  logic       prev_en = 1'b0;
  logic [8:0] prev_bus = '0;
  logic       rw_bad = 1'b0;
  logic       bus_bad = 1'b0;
  logic [8:0] q_byte[$];
  int         q_rise[$];
  int         q_width[$];
  int         acc_cyc[$];
  logic [7:0] acc_data[$];

  always @(negedge clk) begin
    cyc++;
    if (lcd_rw !== 1'b0) rw_bad = 1'b1;
    if (lcd_en && !prev_en) begin
      q_byte.push_back({lcd_rs, lcd_data});
      q_rise.push_back(cyc);
      if ({lcd_rs, lcd_data} != prev_bus) bus_bad = 1'b1;
      width = 1;
    end else if (lcd_en) begin
      width++;
      if ({lcd_rs, lcd_data} != prev_bus) bus_bad = 1'b1;
    end else if (prev_en) begin
      q_width.push_back(width);
    end
    if (rst && req_valid && req_ready) begin
      acc_cyc.push_back(cyc);
      acc_data.push_back(req_data);
    end
    prev_en  = lcd_en;
    prev_bus = {lcd_rs, lcd_data};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_queues();
    q_byte.delete();
    q_rise.delete();
    q_width.delete();
    acc_cyc.delete();
    acc_data.delete();
  endtask

  // Caller has just set rst=1; cycle 1 is the one following the first edge with rst high.
  task automatic run_init(input bit poke);
    logic [8:0] exp_b[6];
    int c;
    exp_b = '{9'h038, 9'h038, 9'h038, 9'h00C, 9'h001, 9'h006};
    c = 0;
    while (c < 200) begin
      step();
      c++;
      if (c == 1) check("lcd_on_after_release", 32'(lcd_on), 32'd1);
      if (poke && c == 40) begin
        req_valid = 1'b1;
        req_rs    = 1'b1;
        req_data  = 8'h77;
      end
      if (poke && c == 41) begin
        req_valid = 1'b0;
        check("status_busy_init", status, 32'h1);
      end
      if (init_done) break;
    end
    check("init_cycles", 32'(c), 32'd85);
    check("init_ready", 32'(req_ready), 32'd1);
    check("init_status", status, 32'h2);
    check("init_pulse_count", 32'(q_byte.size()), 32'd6);
    for (int i = 0; i < q_byte.size() && i < 6; i++) begin
      check($sformatf("init_byte%0d", i), 32'(q_byte[i]), 32'(exp_b[i]));
      if (i < q_width.size())
        check($sformatf("init_width%0d", i), 32'(q_width[i]), 32'd3);
    end
    if (q_rise.size() == 6) begin
      check("init_gap_cmd", 32'(q_rise[1] - q_rise[0]), 32'd10);
      check("init_gap_clr", 32'(q_rise[5] - q_rise[4]), 32'd25);
    end
  endtask

  // One request from IDLE; returns the cycle (after acceptance) where ready rises.
  task automatic send(input logic rs, input logic [7:0] d, output int c);
    req_valid = 1'b1;
    req_rs    = rs;
    req_data  = d;
    step();
    req_valid = 1'b0;
    req_rs    = ~rs;
    req_data  = ~d;
    c = 1;
    check("send_ready_low", 32'(req_ready), 32'd0);
    while (!req_ready && c < 200) begin
      if (c == 2) check("send_en_c2", 32'(lcd_en), 32'd0);
      if (c == 3) check("send_en_c3", 32'(lcd_en), 32'd1);
      if (c == 4) check("send_bus_c4", 32'({lcd_rs, lcd_data}), 32'({rs, d}));
      if (c == 5) check("send_en_c5", 32'(lcd_en), 32'd1);
      if (c == 6) check("send_en_c6", 32'(lcd_en), 32'd0);
      step();
      c++;
    end
  endtask

  initial begin
    int c;
    rst       = 1'b0;
    req_valid = 1'b0;
    req_rs    = 1'b0;
    req_data  = 8'h00;

    step();
    step();
    check("rst_en", 32'(lcd_en), 32'd0);
    check("rst_data", 32'(lcd_data), 32'h00);
    check("rst_on", 32'(lcd_on), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_status", status, 32'h1);
    clear_queues();
    rst = 1'b1;
    run_init(1'b0);

    clear_queues();
    send(1'b1, 8'h41, c);
    check("data_ready_cycle", 32'(c), 32'd11);
    send(1'b0, 8'h01, c);
    check("clear_ready_cycle", 32'(c), 32'd26);
    send(1'b0, 8'h80, c);
    check("cmd80_ready_cycle", 32'(c), 32'd11);
    check("send_pulses", 32'(q_byte.size()), 32'd3);

    // Back-to-back with req_valid held high.
    clear_queues();
    req_valid = 1'b1;
    req_rs    = 1'b1;
    req_data  = 8'h48;
    step();
    req_data = 8'h49;
    step();
    check("b2b_hold", 32'(lcd_data), 32'h48);
    c = 0;
    while (!req_ready && c < 100) begin
      step();
      c++;
    end
    step();
    req_valid = 1'b0;
    c = 0;
    while (!req_ready && c < 100) begin
      step();
      c++;
    end
    check("b2b_accepts", 32'(acc_cyc.size()), 32'd2);
    if (acc_cyc.size() == 2) check("b2b_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'd11);
    check("b2b_pulses", 32'(q_byte.size()), 32'd2);
    if (q_byte.size() == 2) begin
      check("b2b_byte0", 32'(q_byte[0]), 32'h148);
      check("b2b_byte1", 32'(q_byte[1]), 32'h149);
    end

    // Reset in the middle of an EN pulse.
    req_valid = 1'b1;
    req_rs    = 1'b1;
    req_data  = 8'h5A;
    step();
    req_valid = 1'b0;
    c = 0;
    while (!lcd_en && c < 20) begin
      step();
      c++;
    end
    check("midrst_en_seen", 32'(lcd_en), 32'd1);
    rst = 1'b0;
    step();
    check("midrst_en", 32'(lcd_en), 32'd0);
    check("midrst_data", 32'(lcd_data), 32'h00);
    check("midrst_on", 32'(lcd_on), 32'd0);
    check("midrst_init_done", 32'(init_done), 32'd0);
    check("midrst_ready", 32'(req_ready), 32'd0);
    step();
    clear_queues();
    rst = 1'b1;
    run_init(1'b1);

    check("rw_never_high", 32'(rw_bad), 32'd0);
    check("bus_stable_at_en", 32'(bus_bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
